// File: rtl/opl_pkg.sv
// Shared OPL operator-path definitions: widths, sample types and the
// exponent ROM contents used by the antilog converter.
package opl_pkg;

    localparam int unsigned OPL_ATT_W     = 13;
    localparam int unsigned OPL_OUT_W     = 13;
    localparam int unsigned OPL_EXP_ROM_W = 10;

    typedef logic        [OPL_ATT_W-1:0] opl_att_t;
    typedef logic signed [OPL_OUT_W-1:0] opl_sample_t;

    // Builds the 256-entry exp table, entry i = round((2^(i/256) - 1) * 1024),
    // packed as entry i at bits [i*10 +: 10]. Evaluated at elaboration only, in
    // 60-bit fixed point: ln2 from its series, then exp(x) by Taylor expansion.
    function automatic logic [OPL_EXP_ROM_W*256-1:0] opl_exp_rom_init();
        logic [127:0]                   one;
        logic [127:0]                   ln2;
        logic [127:0]                   x;
        logic [127:0]                   term;
        logic [127:0]                   sum;
        logic [127:0]                   v;
        logic [OPL_EXP_ROM_W*256-1:0]   rom;
        one = 128'd1 << 60;
        ln2 = '0;
        for (int k = 1; k <= 64; k++) begin
            ln2 = ln2 + ((one >> k) / 128'(k));
        end
        rom = '0;
        for (int i = 0; i < 256; i++) begin
            x    = (ln2 * 128'(i)) >> 8;
            term = one;
            sum  = one;
            for (int k = 1; k <= 24; k++) begin
                term = ((term * x) >> 60) / 128'(k);
                sum  = sum + term;
            end
            // Scale the fractional part by 1024 and round half up.
            v = ((sum - one) << 10) + (one >> 1);
            rom[i*OPL_EXP_ROM_W +: OPL_EXP_ROM_W] = v[69:60];
        end
        return rom;
    endfunction

endpackage

// File: rtl/opl_exp_lut.sv
// 256x10 registered exponent ROM. Output resets to 0 and holds while en = 0.
module opl_exp_lut
    import opl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [7:0]               theta,
    output logic [OPL_EXP_ROM_W-1:0] out
);

    localparam logic [OPL_EXP_ROM_W*256-1:0] ROM_BITS = opl_exp_rom_init();

    // Registered table read, frozen while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (en) begin
            out <= ROM_BITS[32'(theta)*OPL_EXP_ROM_W +: OPL_EXP_ROM_W];
        end
    end

endmodule

// File: rtl/opl_exp_converter.sv
// Log-attenuation to linear signed sample converter (antilog stage).
// Pipeline: exp-ROM lookup -> mantissa shift -> sign apply, valid/ready.
// Build option OPL_EXP_TWOS_COMPLEMENT_EN: negate with twos complement
// instead of the hardware-accurate ones complement.
module opl_exp_converter
    import opl_pkg::*;
#(
    parameter int unsigned ATT_W = OPL_ATT_W,
    parameter int unsigned OUT_W = OPL_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ATT_W-1:0]        log_att,
    input  logic                    sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out
);

    logic                     stall;
    logic                     en;
    logic [OPL_EXP_ROM_W-1:0] rom1;
    logic [ATT_W-9:0]         shift1;
    logic                     sign1;
    logic                     v1;
    logic [11:0]              mag_d;
    logic [11:0]              mag2;
    logic                     sign2;
    logic                     v2;
    logic [OUT_W-1:0]         pos;
    logic [OUT_W-1:0]         out_d;

    // Whole pipeline freezes while the consumer refuses a valid output.
    always_comb begin
        stall    = out_valid & ~out_ready;
        en       = ~stall;
        in_ready = ~stall;
    end

    // Stage 1: ROM addressed by the inverted fraction.
    opl_exp_lut u_exp_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .theta (~log_att[7:0]),
        .out   (rom1)
    );

    // Stage 1 side-band: integer shift, sign and valid travel with the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift1 <= '0;
            sign1  <= 1'b0;
            v1     <= 1'b0;
        end else if (en) begin
            shift1 <= log_att[ATT_W-1:8];
            sign1  <= sign;
            v1     <= in_valid;
        end
    end

    // Restore the implicit leading one, then shift down by the integer part.
    always_comb begin
        mag_d = '0;
        if (shift1 < 12) begin
            mag_d = {1'b1, rom1, 1'b0} >> shift1;
        end
    end

    // Stage 2 register: magnitude, sign, valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag2  <= '0;
            sign2 <= 1'b0;
            v2    <= 1'b0;
        end else if (en) begin
            mag2  <= mag_d;
            sign2 <= sign1;
            v2    <= v1;
        end
    end

    // Sign application; the default ones complement turns -0 into -1.
    always_comb begin
        pos = {{(OUT_W-12){1'b0}}, mag2};
`ifdef OPL_EXP_TWOS_COMPLEMENT_EN
        out_d = sign2 ? (~pos + 1'b1) : pos;
`else
        out_d = sign2 ? ~pos : pos;
`endif
    end

    // Stage 3: output only updates on a valid sample so bubbles leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                out <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_opl_exp_converter.sv
// Self-checking bench for opl_exp_converter: vector table, streaming,
// backpressure and mid-stream reset, with a scoreboard queue on the output.
module tb_opl_exp_converter;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [12:0]        log_att;
    logic               sign;
    logic               out_valid;
    logic               out_ready;
    logic signed [12:0] out;

    int vectors     = 0;
    int miscompares = 0;
    int expq[$];

    typedef struct {
        string name;
        int    att;
        bit    sgn;
        int    exp_out;
    } vec_t;

    vec_t tbl[8];

    opl_exp_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_att   (log_att),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Independent reference: real-valued antilog, then shift and sign.
    function automatic int model(input int att, input bit s);
        int r;
        int sh;
        int m;
        r  = $rtoi(($pow(2.0, real'((~att) & 255) / 256.0) - 1.0) * 1024.0 + 0.5);
        sh = (att >> 8) & 31;
        m  = (sh >= 12) ? 0 : (((1024 + r) * 2) >> sh);
`ifdef OPL_EXP_TWOS_COMPLEMENT_EN
        return s ? -m : m;
`else
        return s ? (-m - 1) : m;
`endif
    endfunction

    // Output monitor: scoreboard push on input transfer, pop on output transfer.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", int'(in_ready), (out_valid && !out_ready) ? 0 : 1);
            if (out_valid && !out_ready && expq.size() != 0) begin
                chk("stall hold", int'(out), expq[0]);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("unexpected output", 1, 0);
                else chk("scoreboard out", int'(out), expq.pop_front());
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(int'(log_att), sign));
            end
        end
    end

    // Single isolated sample; call at posedge+1 with an empty pipeline.
    task automatic run_one(input string name, input int att, input bit s, input int exp_out);
        int lat;
        in_valid = 1'b1;
        log_att  = 13'(att);
        sign     = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, lat, 3);
        chk(name, int'(out), exp_out);
    endtask

    initial begin
        int sent;
        int cyc;
        bit acc;

        tbl[0] = '{"att 0x000", 'h000, 1'b0, 4084};
        tbl[1] = '{"att 0x0FF", 'h0FF, 1'b0, 2048};
        tbl[2] = '{"att 0x100", 'h100, 1'b0, 2042};
        tbl[3] = '{"att 0xC00", 'hC00, 1'b0, 0};
        tbl[4] = '{"att 0x1FFF", 'h1FFF, 1'b0, 0};
`ifdef OPL_EXP_TWOS_COMPLEMENT_EN
        tbl[5] = '{"neg 0x000", 'h000, 1'b1, -4084};
        tbl[6] = '{"neg 0xC00", 'hC00, 1'b1, 0};
        tbl[7] = '{"neg 0x0FF", 'h0FF, 1'b1, -2048};
`else
        tbl[5] = '{"neg 0x000", 'h000, 1'b1, -4085};
        tbl[6] = '{"neg 0xC00", 'hC00, 1'b1, -1};
        tbl[7] = '{"neg 0x0FF", 'h0FF, 1'b1, -2049};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        log_att   = '0;
        sign      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out", int'(out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset out_valid", int'(out_valid), 0);
        chk("post-reset out", int'(out), 0);
        chk("post-reset in_ready", int'(in_ready), 1);

        foreach (tbl[i]) begin
            run_one(tbl[i].name, tbl[i].att, tbl[i].sgn, tbl[i].exp_out);
        end

        // Streaming: 16 back-to-back samples, outputs on edges 3..18.
        for (int e = 1; e <= 20; e++) begin
            in_valid = (e <= 16);
            if (e <= 16) begin
                log_att = 13'($urandom_range(0, 8191));
                sign    = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            chk("stream out_valid", int'(out_valid), (e >= 3 && e <= 18) ? 1 : 0);
        end
        in_valid = 1'b0;
        chk("stream drained", expq.size(), 0);

        // Backpressure: out_ready low for 5 cycles mid-stream.
        sent     = 0;
        cyc      = 0;
        in_valid = 1'b1;
        log_att  = 13'($urandom_range(0, 8191));
        sign     = 1'($urandom_range(0, 1));
        while (sent < 12 && cyc < 100) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                log_att = 13'($urandom_range(0, 8191));
                sign    = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp samples sent", sent, 12);
        cyc = 0;
        while (expq.size() != 0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp drained", expq.size(), 0);

        // Reset with three samples in flight.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            log_att  = 13'(k * 'h155);
            sign     = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre-reset out_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", int'(out_valid), 0);
        chk("async reset out", int'(out), 0);
        expq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("no stale sample", int'(out_valid), 0);
        end
        run_one("after reset", tbl[1].att, tbl[1].sgn, tbl[1].exp_out);
        @(posedge clk);
        #1;
        chk("final drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors %0d miscompares %0d",
                 vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
